// File: rtl/uart_pkg.sv
// Shared types and default constants for the UART transmit scheduler.
// Optional watchdog feature is selected with UART_TX_SCHED_TIMEOUT_EN.
package uart_pkg;

  // Scheduler FSM states
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    PULSE     = 2'd1,
    WAIT_BUSY = 2'd2,
    WAIT_IDLE = 2'd3
  } sched_state_e;

  // One full brclk16 period in clk cycles
  localparam int EN_CYCLES_DEFAULT    = 325;
  // Watchdog limit while waiting on the sender
  localparam int BUSY_TIMEOUT_DEFAULT = 4096;

endpackage

// File: rtl/rr_arb.sv
// Combinational round-robin arbiter: picks the first set request at or
// after the pointer, wrapping modulo NREQ. The pointer lives in the parent.
import uart_pkg::*;

module rr_arb #(
  parameter int NREQ = 2,
  parameter int PW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [PW-1:0]   ptr,
  output logic            valid,
  output logic [PW-1:0]   winner
);

  // Scan from the farthest offset down so the nearest set request wins last
  always_comb begin
    int idx;
    valid  = 1'b0;
    winner = '0;
    idx    = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % NREQ;
      if (req[idx]) begin
        valid  = 1'b1;
        winner = PW'(idx);
      end
    end
  end

endmodule

// File: rtl/uart_tx_sched.sv
// Round-robin scheduler sharing one UART sender between NREQ byte producers.
// Grants one byte, holds tx_en for EN_CYCLES, then waits for the sender to
// go busy and back to idle before the next grant.
// Define UART_TX_SCHED_TIMEOUT_EN to add a watchdog on the WAIT states that
// raises the sticky err flag and returns to IDLE.
import uart_pkg::*;

module uart_tx_sched #(
  parameter int NREQ         = 2,
  parameter int EN_CYCLES    = EN_CYCLES_DEFAULT,
  parameter int BUSY_TIMEOUT = BUSY_TIMEOUT_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              sched_en,
  input  logic [NREQ-1:0]   req,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   ack,
  input  logic              tx_status,
  output logic [7:0]        tx_data,
  output logic              tx_en,
  output logic              busy,
  output logic              err,
  input  logic              err_clr
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (EN_CYCLES > 1) ? $clog2(EN_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(EN_CYCLES - 1);
  localparam logic [PW-1:0] PTR_LAST = PW'(NREQ - 1);

  sched_state_e    state_q;
  logic [PW-1:0]   ptr_q;
  logic [CW-1:0]   cnt_q;
  logic            seen_busy_q;
  logic [NREQ-1:0] ack_q;
  logic [7:0]      tx_data_q;
  logic            tx_en_q;

  logic            arb_valid;
  logic [PW-1:0]   arb_winner;
  logic [7:0]      req_byte [NREQ];

  // Split the flat data bus into one byte per requester
  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_bytes
      assign req_byte[gi] = req_data[8*gi +: 8];
    end
  endgenerate

  rr_arb #(.NREQ(NREQ), .PW(PW)) u_arb (
    .req    (req),
    .ptr    (ptr_q),
    .valid  (arb_valid),
    .winner (arb_winner)
  );

`ifdef UART_TX_SCHED_TIMEOUT_EN
  localparam int WW = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;
  localparam logic [WW-1:0] WDOG_LAST = WW'(BUSY_TIMEOUT - 1);
  logic [WW-1:0] wdog_q;
  logic          err_q;
`else
  localparam int unused_busy_timeout = BUSY_TIMEOUT;
  logic          unused_err_clr;
  assign unused_err_clr = err_clr;
`endif

  // Scheduler FSM with registered grant, data and enable outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= IDLE;
      ptr_q       <= '0;
      cnt_q       <= '0;
      seen_busy_q <= 1'b0;
      ack_q       <= '0;
      tx_data_q   <= 8'h00;
      tx_en_q     <= 1'b0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      wdog_q      <= '0;
      err_q       <= 1'b0;
`endif
    end else begin
      ack_q <= '0;
`ifdef UART_TX_SCHED_TIMEOUT_EN
      if (err_clr) err_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (sched_en && arb_valid && tx_status) begin
            tx_data_q <= req_byte[arb_winner];
            ack_q     <= NREQ'(1) << arb_winner;
            tx_en_q   <= 1'b1;
            cnt_q     <= '0;
            ptr_q     <= (arb_winner == PTR_LAST) ? '0 : arb_winner + 1'b1;
            state_q   <= PULSE;
          end
        end
        PULSE: begin
          if (!tx_status) seen_busy_q <= 1'b1;
          if (cnt_q == CNT_LAST) begin
            tx_en_q <= 1'b0;
            state_q <= (seen_busy_q || !tx_status) ? WAIT_IDLE : WAIT_BUSY;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        WAIT_BUSY: begin
          if (!tx_status) state_q <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (tx_status) begin
            seen_busy_q <= 1'b0;
            state_q     <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
`ifdef UART_TX_SCHED_TIMEOUT_EN
      // Watchdog overrides the WAIT-state transitions; timeout beats err_clr
      if (state_q == WAIT_BUSY || state_q == WAIT_IDLE) begin
        if (wdog_q == WDOG_LAST) begin
          err_q       <= 1'b1;
          seen_busy_q <= 1'b0;
          wdog_q      <= '0;
          state_q     <= IDLE;
        end else begin
          wdog_q <= wdog_q + 1'b1;
        end
      end else begin
        wdog_q <= '0;
      end
`endif
    end
  end

  assign ack     = ack_q;
  assign tx_data = tx_data_q;
  assign tx_en   = tx_en_q;
  assign busy    = (state_q != IDLE);
`ifdef UART_TX_SCHED_TIMEOUT_EN
  assign err     = err_q;
`else
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed testbench for uart_tx_sched (NREQ=2, EN_CYCLES=325).
// With UART_TX_SCHED_TIMEOUT_EN defined, BUSY_TIMEOUT=64 and the watchdog
// scenario is exercised; otherwise err is checked to stay at 0.
module tb_uart_tx_sched;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        sched_en = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [15:0] req_data = 16'h0000;
  logic [1:0]  ack;
  logic        tx_status = 1'b1;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        busy;
  logic        err;
  logic        err_clr = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_sched #(
    .NREQ(2),
    .EN_CYCLES(325)
`ifdef UART_TX_SCHED_TIMEOUT_EN
    , .BUSY_TIMEOUT(64)
`endif
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .sched_en  (sched_en),
    .req       (req),
    .req_data  (req_data),
    .ack       (ack),
    .tx_status (tx_status),
    .tx_data   (tx_data),
    .tx_en     (tx_en),
    .busy      (busy),
    .err       (err),
    .err_clr   (err_clr)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    sched_en  = 1'b0;
    req       = 2'b00;
    err_clr   = 1'b0;
    tx_status = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_tx_en_low();
    for (int i = 0; i < 1000 && tx_en; i++) tick();
  endtask

  // Sender model: goes busy for one cycle, then back to idle
  task automatic finish_byte();
    wait_tx_en_low();
    tx_status = 1'b0;
    tick();
    tx_status = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (tx_en !== 1'b0)   begin n_fail++; $display("FAIL reset_tx_en: got %b expected 0", tx_en); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL reset_tx_data: got %h expected 00", tx_data); end
    n_checks++; if (ack !== 2'b00)    begin n_fail++; $display("FAIL reset_ack: got %b expected 00", ack); end
    n_checks++; if (busy !== 1'b0)    begin n_fail++; $display("FAIL reset_busy: got %b expected 0", busy); end
    n_checks++; if (err !== 1'b0)     begin n_fail++; $display("FAIL reset_err: got %b expected 0", err); end
    $display("reset: tx_en=%b tx_data=%h ack=%b busy=%b err=%b", tx_en, tx_data, ack, busy, err);
  endtask

  task automatic test_single();
    int n_high;
    do_reset();
    sched_en  = 1'b1;
    tx_status = 1'b1;
    req_data  = 16'h0041;
    req       = 2'b01;
    tick();
    n_checks++; if (ack !== 2'b01)     begin n_fail++; $display("FAIL single_ack: got %b expected 01", ack); end
    n_checks++; if (tx_en !== 1'b1)    begin n_fail++; $display("FAIL single_tx_en: got %b expected 1", tx_en); end
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_tx_data: got %h expected 41", tx_data); end
    n_checks++; if (busy !== 1'b1)     begin n_fail++; $display("FAIL single_busy: got %b expected 1", busy); end
    req = 2'b00;
    n_high = 1;
    tick();
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL single_ack_pulse: got %b expected 00", ack); end
    while (tx_en && n_high < 1000) begin
      n_high++;
      tick();
    end
    n_checks++; if (n_high !== 325) begin n_fail++; $display("FAIL single_en_width: got %0d expected 325", n_high); end
    tick();
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_busy: got %b expected 1", busy); end
    tx_status = 1'b0;
    tick();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL single_wait_idle: got %b expected 1", busy); end
    tx_status = 1'b1;
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_done_busy: got %b expected 0", busy); end
    tick();
    n_checks++; if (tx_data !== 8'h41) begin n_fail++; $display("FAIL single_data_hold: got %h expected 41", tx_data); end
    $display("single: byte=%h en_cycles=%0d busy=%b", tx_data, n_high, busy);
  endtask

  task automatic test_alternate();
    logic [1:0] exp_ack;
    logic [7:0] exp_data;
    do_reset();
    sched_en  = 1'b1;
    req_data  = 16'h55AA;
    req       = 2'b11;
    for (int g = 0; g < 4; g++) begin
      int w;
      w = 0;
      exp_ack  = (g % 2 == 0) ? 2'b01 : 2'b10;
      exp_data = (g % 2 == 0) ? 8'hAA : 8'h55;
      while (ack == 2'b00 && w < 20) begin
        tick();
        w++;
      end
      n_checks++; if (ack !== exp_ack)   begin n_fail++; $display("FAIL alt_ack[%0d]: got %b expected %b", g, ack, exp_ack); end
      n_checks++; if (tx_data !== exp_data) begin n_fail++; $display("FAIL alt_data[%0d]: got %h expected %h", g, tx_data, exp_data); end
      $display("alternate grant %0d: ack=%b tx_data=%h", g, ack, tx_data);
      finish_byte();
    end
    req = 2'b00;
    tick();
  endtask

  task automatic test_sched_en();
    do_reset();
    req_data = 16'h55AA;
    sched_en = 1'b0;
    // A request dropped before any grant leaves no trace
    req = 2'b10;
    tick();
    tick();
    req = 2'b00;
    sched_en = 1'b1;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL dropped_req_busy: got %b expected 0", busy); end
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL dropped_req_ack: got %b expected 00", ack); end
    sched_en = 1'b0;
    req = 2'b11;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL sched_off_ack: got %b expected 00", ack); end
    n_checks++; if (tx_en !== 1'b0) begin n_fail++; $display("FAIL sched_off_tx_en: got %b expected 0", tx_en); end
    sched_en = 1'b1;
    tick();
    n_checks++; if (ack !== 2'b01)     begin n_fail++; $display("FAIL sched_on_ack: got %b expected 01", ack); end
    n_checks++; if (tx_data !== 8'hAA) begin n_fail++; $display("FAIL sched_on_data: got %h expected aa", tx_data); end
    $display("sched_en: grant ack=%b tx_data=%h", ack, tx_data);
    req = 2'b00;
    finish_byte();
  endtask

  task automatic test_sender_busy();
    do_reset();
    sched_en  = 1'b1;
    req_data  = 16'h3300;
    tx_status = 1'b0;
    req       = 2'b10;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (ack !== 2'b00) begin n_fail++; $display("FAIL sender_busy_ack: got %b expected 00", ack); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL sender_busy_state: got %b expected 0", busy); end
    tx_status = 1'b1;
    tick();
    n_checks++; if (ack !== 2'b10)     begin n_fail++; $display("FAIL sender_free_ack: got %b expected 10", ack); end
    n_checks++; if (tx_en !== 1'b1)    begin n_fail++; $display("FAIL sender_free_tx_en: got %b expected 1", tx_en); end
    n_checks++; if (tx_data !== 8'h33) begin n_fail++; $display("FAIL sender_free_data: got %h expected 33", tx_data); end
    $display("sender_busy: grant ack=%b tx_data=%h", ack, tx_data);
    req = 2'b00;
    finish_byte();
  endtask

  task automatic test_reset_mid();
    do_reset();
    sched_en = 1'b1;
    req_data = 16'h55AA;
    req      = 2'b01;
    tick();
    req = 2'b00;
    for (int i = 0; i < 99; i++) tick();
    n_checks++; if (tx_en !== 1'b1) begin n_fail++; $display("FAIL mid_pre_tx_en: got %b expected 1", tx_en); end
    reset = 1'b0;
    tick();
    n_checks++; if (tx_en !== 1'b0)    begin n_fail++; $display("FAIL mid_tx_en: got %b expected 0", tx_en); end
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("FAIL mid_busy: got %b expected 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL mid_tx_data: got %h expected 00", tx_data); end
    reset = 1'b1;
    req   = 2'b11;
    tick();
    n_checks++; if (ack !== 2'b01) begin n_fail++; $display("FAIL mid_ptr: got %b expected 01", ack); end
    $display("reset_mid: after reset grant ack=%b", ack);
    req = 2'b00;
    finish_byte();
  endtask

`ifdef UART_TX_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    int k;
    do_reset();
    sched_en  = 1'b1;
    tx_status = 1'b1;
    req_data  = 16'h0041;
    req       = 2'b01;
    tick();
    req = 2'b00;
    wait_tx_en_low();
    k = 0;
    while (!err && k < 200) begin
      tick();
      k++;
    end
    n_checks++; if (k !== 64)      begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 64", k); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL timeout_idle: got %b expected 0", busy); end
    tick();
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %b expected 1", err); end
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL timeout_clr: got %b expected 0", err); end
    $display("timeout: fired after %0d cycles, err after clear=%b", k, err);
  endtask
`else
  task automatic test_no_timeout();
    do_reset();
    sched_en  = 1'b1;
    tx_status = 1'b1;
    req_data  = 16'h0041;
    req       = 2'b01;
    tick();
    req = 2'b00;
    wait_tx_en_low();
    err_clr = 1'b1;
    for (int i = 0; i < 200; i++) tick();
    err_clr = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL no_wdog_busy: got %b expected 1", busy); end
    n_checks++; if (err !== 1'b0)  begin n_fail++; $display("FAIL no_wdog_err: got %b expected 0", err); end
    $display("no_timeout: busy=%b err=%b after 200 waiting cycles", busy, err);
    finish_byte();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_alternate();
    test_sched_en();
    test_sender_busy();
    test_reset_mid();
`ifdef UART_TX_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
